// File: rtl/int_entry_seq.sv
// Interrupt entry sequencer.
// Accepts a pending interrupt at an instruction boundary, pushes the return PC
// onto the stack as two byte writes, then strobes the vector into PC, moves SP
// down by two, clears the global enable and retires the source upstream.
module int_entry_seq #(
    parameter int ADDR_W      = 16,
    parameter bit PUSH_HI_1ST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cauch_int,
    input  logic [ADDR_W-1:0] int_address,
    input  logic              insn_boundary,
    input  logic              ie,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] sp,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_new,
    output logic              sp_load,
    output logic [ADDR_W-1:0] sp_new,
    output logic              ie_clear,
    output logic              clr_int
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PUSH1  = 3'd1,
        S_PUSH2  = 3'd2,
        S_VECTOR = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic [ADDR_W-1:0] vec_q, vec_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              accept;
    logic [7:0]        first_byte;
    logic [7:0]        second_byte;

    // An interrupt is taken only between instructions with interrupts enabled.
    assign accept = cauch_int & ie & insn_boundary;

    // Byte order on the stack is fixed at elaboration.
    assign first_byte  = PUSH_HI_1ST ? ret_q[15:8] : ret_q[7:0];
    assign second_byte = PUSH_HI_1ST ? ret_q[7:0]  : ret_q[15:8];

    // State and operand registers; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from the
        // same pre-edge values, so ordering inside this block does not matter.
        if (reset) begin
            state_q <= S_IDLE;
            ret_q   <= '0;
            vec_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            vec_q   <= vec_d;
            base_q  <= base_d;
        end
    end

    // Next-state and operand capture: operands are frozen at accept so the
    // push sequence ignores later changes on pc, sp, int_address and ie.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        ret_d   = ret_q;
        vec_d   = vec_q;
        base_d  = base_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ret_d  = pc;
                    vec_d  = int_address;
                    base_d = sp;
                    // A zero vector means no real source: stay idle.
                    if (int_address != '0) begin
                        state_d = S_PUSH1;
                    end
                end
            end
            S_PUSH1: begin
                if (mem_ready) begin
                    state_d = S_PUSH2;
                end
            end
            S_PUSH2: begin
                if (mem_ready) begin
                    state_d = S_VECTOR;
                end
            end
            S_VECTOR: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state and frozen operands only.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b1;
        pc_load   = 1'b0;
        pc_new    = '0;
        sp_load   = 1'b0;
        sp_new    = '0;
        ie_clear  = 1'b0;
        clr_int   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_PUSH1: begin
                mem_we    = 1'b1;
                mem_addr  = base_q;
                mem_wdata = first_byte;
            end
            S_PUSH2: begin
                mem_we    = 1'b1;
                mem_addr  = base_q - ADDR_W'(1);
                mem_wdata = second_byte;
            end
            S_VECTOR: begin
                pc_load  = 1'b1;
                pc_new   = vec_q;
                sp_load  = 1'b1;
                sp_new   = base_q - ADDR_W'(2);
                ie_clear = 1'b1;
                clr_int  = 1'b1;
            end
            S_ACK: begin
                // Gives the upstream registered cauch_int a cycle to drop.
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_int_entry_seq.sv
// Self-checking bench for int_entry_seq: directed stimulus pushes expected
// stack writes and vector events into a queue; a negedge monitor consumes them.
module tb_int_entry_seq;

    logic        clk;
    logic        reset;
    logic        cauch_int;
    logic [15:0] int_address;
    logic        insn_boundary;
    logic        ie;
    logic [15:0] pc;
    logic [15:0] sp;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        sp_load;
    logic [15:0] sp_new;
    logic        ie_clear;
    logic        clr_int;

    int_entry_seq dut (
        .clk          (clk),
        .reset        (reset),
        .cauch_int    (cauch_int),
        .int_address  (int_address),
        .insn_boundary(insn_boundary),
        .ie           (ie),
        .pc           (pc),
        .sp           (sp),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .busy         (busy),
        .pc_load      (pc_load),
        .pc_new       (pc_new),
        .sp_load      (sp_load),
        .sp_new       (sp_new),
        .ie_clear     (ie_clear),
        .clr_int      (clr_int)
    );

    typedef struct {
        bit          is_vec;
        logic [15:0] a;    // write address, or expected pc_new
        logic [15:0] d;    // write data, or expected sp_new
        int          cyc;  // expected cycle of the vector strobe
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
    endtask

    // Advance to just after the posedge that makes cyc == c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance to the negedge inside cycle c.
    task automatic at_neg(input int c);
        goto(c);
        @(negedge clk);
    endtask

    // Raise an interrupt for one cycle and queue the full expected response.
    task automatic issue(input logic [15:0] p, input logic [15:0] s,
                         input logic [15:0] v, input int stall, output int t0);
        exp_t e;
        t0 = cyc;
        cauch_int = 1'b1; ie = 1'b1; insn_boundary = 1'b1;
        pc = p; sp = s; int_address = v;
        mem_ready = (stall == 0);
        e = '{is_vec: 1'b0, a: s,          d: {8'h00, p[15:8]}, cyc: 0}; q.push_back(e);
        e = '{is_vec: 1'b0, a: s - 16'd1,  d: {8'h00, p[7:0]},  cyc: 0}; q.push_back(e);
        e = '{is_vec: 1'b1, a: v,          d: s - 16'd2,        cyc: t0 + 3 + stall}; q.push_back(e);
        goto(t0 + 1);
        cauch_int = 1'b0; insn_boundary = 1'b0; pc = 16'hDEAD; sp = 16'hBEEF;
        if (stall > 0) begin
            goto(t0 + 1 + stall);
            mem_ready = 1'b1;
        end
    endtask

    // Monitor: consume accepted writes and vector strobes, check bus idling
    // and hold-stability during a stalled write.
    logic        prev_stall = 1'b0;
    logic        prev_reset = 1'b0;
    logic [15:0] prev_addr  = '0;
    logic [7:0]  prev_data  = '0;

    always @(negedge clk) begin
        if (prev_stall && !prev_reset) begin
            check("hold_we",   {31'd0, mem_we}, 32'd1);
            check("hold_addr", {16'd0, mem_addr}, {16'd0, prev_addr});
            check("hold_data", {24'd0, mem_wdata}, {24'd0, prev_data});
        end
        if (!mem_we) begin
            check("idle_bus", {8'd0, mem_addr, mem_wdata}, 32'd0);
        end
        if (mem_we && mem_ready) begin
            if (q.size() == 0 || q[0].is_vec) begin
                flag("write_unexpected");
            end else begin
                check("wr_addr", {16'd0, mem_addr}, {16'd0, q[0].a});
                check("wr_data", {24'd0, mem_wdata}, {16'd0, q[0].d});
                void'(q.pop_front());
            end
        end
        if (pc_load || sp_load || ie_clear || clr_int) begin
            if (q.size() == 0 || !q[0].is_vec) begin
                flag("vector_unexpected");
            end else begin
                check("vec_strobes", {28'd0, pc_load, sp_load, ie_clear, clr_int}, 32'hF);
                check("vec_pc_new", {16'd0, pc_new}, {16'd0, q[0].a});
                check("vec_sp_new", {16'd0, sp_new}, {16'd0, q[0].d});
                check("vec_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
        prev_stall = mem_we && !mem_ready;
        prev_reset = reset;
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
    end

    initial begin
        int t0;
        reset = 1'b1; cauch_int = 1'b0; int_address = '0; insn_boundary = 1'b0;
        ie = 1'b0; pc = '0; sp = '0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_strobes", {28'd0, pc_load, sp_load, ie_clear, clr_int}, 32'd0);
        goto(cyc + 1);

        // Basic entry, ready tied high.
        issue(16'h1234, 16'h0FFF, 16'h0080, 0, t0);
        at_neg(t0 + 1); check("t1_busy_push", {31'd0, busy}, 32'd1);
        at_neg(t0 + 3); check("t1_clr_int", {31'd0, clr_int}, 32'd1);
        at_neg(t0 + 4); check("t1_busy_ack", {31'd0, busy}, 32'd1);
                        check("t1_ack_quiet", {28'd0, pc_load, sp_load, ie_clear, clr_int}, 32'd0);
        at_neg(t0 + 5); check("t1_busy_idle", {31'd0, busy}, 32'd0);
        goto(t0 + 7);

        // Three stall cycles in PUSH1.
        issue(16'h1234, 16'h0FFF, 16'h0080, 3, t0);
        at_neg(t0 + 5); check("t2_clr_early", {31'd0, clr_int}, 32'd0);
        at_neg(t0 + 6); check("t2_clr_int", {31'd0, clr_int}, 32'd1);
        at_neg(t0 + 8); check("t2_busy_idle", {31'd0, busy}, 32'd0);
        goto(t0 + 10);

        // Stack pointer wrap.
        issue(16'hABCD, 16'h0000, 16'h0100, 0, t0);
        goto(t0 + 7);

        // Gating: ie low, then boundary low, then zero vector.
        cauch_int = 1'b1; ie = 1'b0; insn_boundary = 1'b1; int_address = 16'h0080;
        t0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            at_neg(t0 + i); check("t4_ie_off_busy", {31'd0, busy}, 32'd0);
        end
        goto(t0 + 5);
        ie = 1'b1; insn_boundary = 1'b0;
        t0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            at_neg(t0 + i); check("t4_bnd_off_busy", {31'd0, busy}, 32'd0);
        end
        goto(t0 + 5);
        insn_boundary = 1'b1; int_address = 16'h0000;
        t0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            at_neg(t0 + i); check("t4_zero_vec_busy", {31'd0, busy}, 32'd0);
        end
        goto(t0 + 5);
        cauch_int = 1'b0; insn_boundary = 1'b0;
        goto(cyc + 2);

        // Reset during PUSH2: only the first write completes.
        t0 = cyc;
        cauch_int = 1'b1; ie = 1'b1; insn_boundary = 1'b1;
        pc = 16'h2468; sp = 16'h3000; int_address = 16'h00C0; mem_ready = 1'b1;
        q.push_back('{is_vec: 1'b0, a: 16'h3000, d: 16'h0024, cyc: 0});
        goto(t0 + 1);
        cauch_int = 1'b0; insn_boundary = 1'b0;
        goto(t0 + 2);
        mem_ready = 1'b0; reset = 1'b1;
        at_neg(t0 + 2); check("t5_in_push2", {31'd0, mem_we}, 32'd1);
        goto(t0 + 3);
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("t5_we_after_rst", {31'd0, mem_we}, 32'd0);
        check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        goto(t0 + 9);
        check("t5_queue_drained", q.size(), 32'd0);

        // Vector change during PUSH1 must not affect the latched vector.
        issue(16'h5A5A, 16'h2000, 16'h0080, 0, t0);
        int_address = 16'h0040; ie = 1'b0; cauch_int = 1'b1;
        pc = 16'h9999; sp = 16'h5555;
        goto(t0 + 6);
        cauch_int = 1'b0;

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < 20 && q.size() != 0; i++) goto(cyc + 1);
        check("final_queue_empty", q.size(), 32'd0);
        @(negedge clk);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
